lv1a_trig_sched: RTL
====================

LV1A_TRIG_SCHED -- requirements
Module: lv1a_trig_sched

Interface
REQ-001 Parameter GATE, default 20, minimum spacing in clk cycles between issued lv1a pulses.
REQ-002 Parameter PSW, default 16, width of the per-type prescale value.
REQ-003 clk  in  1  system clock; all logic on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_live  in  1  run live; low = idle/flush.
REQ-006 in_int_req  in  16  raw internal trigger requests, one per type.
REQ-007 in_ext_req  in  4  external trigger lines.
REQ-008 in_delta_req  in  1  delta trigger request.
REQ-009 in_lv1_inhibit  in  1  lv1 slot in progress; no issue while high.
REQ-010 in_ps_load / in_ps_sel / in_ps_val  in  1/4/PSW  prescale write strobe, type index, value.
REQ-011 in_hold_max  in  8  maximum inhibit-hold cycles before pending requests are dropped; 0 = never drop.
REQ-012 out_int_lv1a / out_ext_lv1a / out_delta_lv1a  out  16/4/1  registered one-cycle issued trigger word.
REQ-013 out_busy  out  1  high when state is not IDLE.
REQ-014 out_issue_cnt / out_drop_cnt / out_merge_cnt  out  32 each  statistics.

Function
REQ-015 Prescale: per internal type, one PSW-bit value register ps[i] and counter pc[i]; ps[i]=0 blocks type i; ps[i]=1 passes every request; ps[i]=N passes requests 1, N+1, 2N+1, ...
REQ-016 Prescale rule: on a raw request of type i, the request passes iff pc[i]==0, then pc[i]=(pc[i]+1) mod ps[i].
REQ-017 in_ps_load=1 writes ps[in_ps_sel]=in_ps_val and clears pc[in_ps_sel]; a request of that type on the same edge is evaluated with the old value.
REQ-018 Ext and delta requests bypass the prescaler.
REQ-019 Pending register P (21 bits = {delta, ext, int}) ORs in prescaled requests each edge.
REQ-020 out_merge_cnt increments when a new request bit lands on a P bit that is already set.
REQ-021 FSM states: IDLE (P=0, gate=0), PEND (P!=0, gate=0), HOLD (P!=0, inhibit seen), GATE (gate counter g>0).
REQ-022 Issue edge: state PEND or HOLD, in_lv1_inhibit=0, and g=0.
REQ-023 Issue actions: the outputs carry P for exactly one cycle after the issue edge; P is cleared; g is loaded with GATE-1; out_issue_cnt increments.
REQ-024 Latency: a request sampled at edge k is issued at edge k+1 at the earliest; a request sampled on the issue edge itself is not in the issued word and stays in P.
REQ-025 GATE state: g decrements once per cycle. At g=0 the FSM goes to PEND if P!=0, else IDLE. Successive issue edges are therefore at least GATE cycles apart.
REQ-026 HOLD: entered when P!=0, g=0 and inhibit=1; hold counter h increments each cycle inhibit stays high.
REQ-027 HOLD exit: if inhibit=1 and h==in_hold_max!=0, P is cleared, out_drop_cnt increments, h clears and the FSM goes to IDLE. If inhibit falls, the pending word issues on that edge.
REQ-028 Outputs default to 0 in every non-issue cycle.
REQ-029 Counters saturate at 32'hFFFFFFFF.
REQ-030 in_live=0 clears P, g, h and all pc[] and forces IDLE with outputs 0; ps[] is retained.
REQ-031 The rising edge of in_live clears all three counters; requests on that edge are accepted.

Reset
REQ-032 rst_n=0 asynchronously clears all outputs, counters, P, g, h and pc[], sets every ps[i]=1, and sets the FSM to IDLE.
REQ-033 After rst_n deasserts, the first edge is a normal edge.

Verification
REQ-034 ps[3]=3, 7 single-cycle int[3] requests spaced 30 cycles apart, live=1 -> issues on requests 1, 4, 7; out_issue_cnt=3.
REQ-035 int[0] at edge 10, ext[2] at edge 12 -> word 0x1 issued at edge 11, ext word 0x4 issued at edge 31; nothing issued between.
REQ-036 delta request with inhibit high for 5 cycles, hold_max=0 -> issued on the edge inhibit falls; drop_cnt=0.
REQ-037 same as REQ-036 with hold_max=3 -> no issue; drop_cnt=1; FSM returns to IDLE.
REQ-038 int[5] requested twice while in GATE -> one issue; merge_cnt=1.
REQ-039 rst_n asserted mid-GATE with P!=0 -> all outputs 0 immediately; no issue after release until a new request arrives.

Source files
------------

// File: rtl/lv1a_trig_sched.sv
// Level-1 accept scheduler: prescales internal triggers, merges all request sources into a
// pending word and issues it subject to lv1 inhibit, a minimum gate spacing and a hold timeout.
module lv1a_trig_sched #(
   parameter int unsigned GATE = 20,
   parameter int unsigned PSW  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_live,
   input  logic [15:0]    in_int_req,
   input  logic [3:0]     in_ext_req,
   input  logic           in_delta_req,
   input  logic           in_lv1_inhibit,
   input  logic           in_ps_load,
   input  logic [3:0]     in_ps_sel,
   input  logic [PSW-1:0] in_ps_val,
   input  logic [7:0]     in_hold_max,
   output logic [15:0]    out_int_lv1a,
   output logic [3:0]     out_ext_lv1a,
   output logic           out_delta_lv1a,
   output logic           out_busy,
   output logic [31:0]    out_issue_cnt,
   output logic [31:0]    out_drop_cnt,
   output logic [31:0]    out_merge_cnt
);

   localparam int unsigned NT = 16;
   localparam int unsigned PW = 21;
   localparam int unsigned GW = (GATE > 1) ? $clog2(GATE) : 1;
   localparam logic [GW-1:0] G_LOAD = GW'(GATE - 1);
   localparam logic [GW-1:0] G_ONE = GW'(1);
   localparam logic [PSW-1:0] PS_ONE = PSW'(1);

   typedef enum logic [1:0] {StIdle, StPend, StHold, StGate} state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [PSW-1:0] ps_q [NT];
   logic [PSW-1:0] pc_q [NT];
   logic [PSW-1:0] pc_nxt [NT];
   logic [NT-1:0]  ps_pass;

   state_e        state_q;
   logic [PW-1:0] pend_q;
   logic [PW-1:0] word_q;
   logic [GW-1:0] gate_q;
   logic [7:0]    hold_q;
   logic          live_q;

   logic [PW-1:0] new_req;
   logic          issue;
   logic          drop;
   logic          merge;

   // Prescaler: pass on pc==0, then advance pc modulo ps; ps==0 blocks the type outright.
   always_comb begin
      for (int i = 0; i < NT; i++) begin
         ps_pass[i] = in_int_req[i] && (ps_q[i] != '0) && (pc_q[i] == '0);
         pc_nxt[i]  = pc_q[i];
         if (in_int_req[i] && (ps_q[i] != '0)) begin
            pc_nxt[i] = ((pc_q[i] + PS_ONE) >= ps_q[i]) ? '0 : pc_q[i] + PS_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NT; i++) begin
            ps_q[i] <= PS_ONE;
            pc_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NT; i++) begin
            pc_q[i] <= in_live ? pc_nxt[i] : '0;
         end
         // A load takes effect after this edge's request was judged with the old value.
         if (in_ps_load) begin
            ps_q[in_ps_sel] <= in_ps_val;
            pc_q[in_ps_sel] <= '0;
         end
      end
   end

   // PEND and HOLD are only ever occupied with the gate counter at zero.
   always_comb begin
      new_req = {in_delta_req, in_ext_req, ps_pass};
      issue   = in_live && !in_lv1_inhibit && ((state_q == StPend) || (state_q == StHold));
      drop    = in_live && in_lv1_inhibit && (state_q == StHold) && (in_hold_max != 8'd0) &&
                (hold_q >= in_hold_max);
      merge   = in_live && !issue && !drop && (|(new_req & pend_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         pend_q        <= '0;
         word_q        <= '0;
         gate_q        <= '0;
         hold_q        <= '0;
         live_q        <= 1'b0;
         out_issue_cnt <= '0;
         out_drop_cnt  <= '0;
         out_merge_cnt <= '0;
      end else begin
         live_q <= in_live;
         word_q <= '0;
         if (!in_live) begin
            state_q <= StIdle;
            pend_q  <= '0;
            gate_q  <= '0;
            hold_q  <= '0;
         end else begin
            if (!live_q) begin
               out_issue_cnt <= '0;
               out_drop_cnt  <= '0;
               out_merge_cnt <= '0;
            end else begin
               if (issue) out_issue_cnt <= sat_inc(out_issue_cnt);
               if (drop)  out_drop_cnt  <= sat_inc(out_drop_cnt);
               if (merge) out_merge_cnt <= sat_inc(out_merge_cnt);
            end

            if (issue) begin
               word_q <= pend_q;
               pend_q <= new_req;
               hold_q <= '0;
               if (GATE > 1) begin
                  gate_q  <= G_LOAD;
                  state_q <= StGate;
               end else begin
                  state_q <= (|new_req) ? StPend : StIdle;
               end
            end else if (drop) begin
               // Requests arriving on the drop edge are kept rather than silently lost.
               pend_q  <= new_req;
               hold_q  <= '0;
               state_q <= (|new_req) ? StPend : StIdle;
            end else begin
               pend_q <= pend_q | new_req;
               unique case (state_q)
                  StIdle: begin
                     if (|new_req) state_q <= StPend;
                  end
                  StPend: begin
                     if (in_lv1_inhibit) begin
                        state_q <= StHold;
                        hold_q  <= 8'd1;
                     end
                  end
                  StHold: begin
                     if (hold_q != 8'hFF) hold_q <= hold_q + 8'd1;
                  end
                  StGate: begin
                     if (gate_q <= G_ONE) begin
                        gate_q  <= '0;
                        state_q <= (|(pend_q | new_req)) ? StPend : StIdle;
                     end else begin
                        gate_q <= gate_q - G_ONE;
                     end
                  end
                  default: state_q <= StIdle;
               endcase
            end
         end
      end
   end

   assign out_int_lv1a   = word_q[15:0];
   assign out_ext_lv1a   = word_q[19:16];
   assign out_delta_lv1a = word_q[20];
   assign out_busy       = (state_q != StIdle);

endmodule
